cest_train_gen: RTL and testbench

Transmit-side channel-estimation training generator for the OFDM chain. On each frame start it emits an N-sample complex training symbol REPEAT times back-to-back, then passes a fixed-length payload through with a valid/ready handshake. It sits ahead of the IFFT in the transmitter. The receiver's channel-estimation averaging block consumes exactly these REPEAT identical copies to form its averaged H.

---
 rtl/cest_train_gen.sv | 172 +++++++++++++++++
 tb/tb_cest_train_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cest_train_gen.sv
// rtl/cest_train_gen.sv - channel-estimation training generator ahead of the IFFT
// Replays an N-sample training table REPEAT times per frame, then streams len payload samples.
module cest_train_gen #(
   parameter int N      = 64,
   parameter int REPEAT = 4,
   parameter int AW     = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tbl_wr_en,
   input  logic [AW-1:0]       tbl_addr,
   input  logic signed [11:0]  tbl_re,
   input  logic signed [11:0]  tbl_im,
   input  logic                start,
   input  logic [11:0]         len,
   input  logic signed [11:0]  din_re,
   input  logic signed [11:0]  din_im,
   input  logic                din_vld,
   output logic                din_rdy,
   output logic signed [11:0]  dout_re,
   output logic signed [11:0]  dout_im,
   output logic                dout_vld,
   output logic                busy,
   output logic                done
);
   localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic [11:0]        len_q, len_d;
   logic [AW-1:0]      addr_cnt_q, addr_cnt_d;
   logic [SW-1:0]      sym_cnt_q, sym_cnt_d;
   logic [11:0]        pay_cnt_q, pay_cnt_d;
   logic               rd_vld_q, rd_vld_d;
   logic               pay_vld_q, pay_vld_d;
   logic signed [11:0] pay_re_q, pay_re_d;
   logic signed [11:0] pay_im_q, pay_im_d;
   logic               last_q, last_d;
   logic signed [11:0] dout_re_q, dout_re_d;
   logic signed [11:0] dout_im_q, dout_im_d;
   logic               dout_vld_q, dout_vld_d;
   logic               done_q, done_d;
   logic               xfer;

   logic [23:0] mem [N];
   logic [23:0] rd_data_q;

   // Table is deliberately outside the reset domain so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (tbl_wr_en && !busy_q) begin
         mem[tbl_addr] <= {tbl_re, tbl_im};
      end
      rd_data_q <= mem[addr_cnt_q];
   end

   assign din_rdy = (state_q == DATA) && (pay_cnt_q < len_q);
   assign xfer    = din_rdy && din_vld;

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      len_d      = len_q;
      addr_cnt_d = addr_cnt_q;
      sym_cnt_d  = sym_cnt_q;
      pay_cnt_d  = pay_cnt_q;
      rd_vld_d   = 1'b0;
      pay_vld_d  = 1'b0;
      pay_re_d   = pay_re_q;
      pay_im_d   = pay_im_q;
      last_d     = 1'b0;

      // Stage 2: one of the two stage-1 sources feeds the output register.
      dout_vld_d = rd_vld_q || pay_vld_q;
      dout_re_d  = 12'sd0;
      dout_im_d  = 12'sd0;
      if (rd_vld_q) begin
         dout_re_d = rd_data_q[23:12];
         dout_im_d = rd_data_q[11:0];
      end else if (pay_vld_q) begin
         dout_re_d = pay_re_q;
         dout_im_d = pay_im_q;
      end
      done_d = last_q;

      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start && !busy_q) begin
               state_d    = TRAIN;
               busy_d     = 1'b1;
               len_d      = len;
               addr_cnt_d = '0;
               sym_cnt_d  = '0;
               pay_cnt_d  = '0;
            end
         end
         TRAIN: begin
            rd_vld_d   = 1'b1;
            addr_cnt_d = addr_cnt_q + AW'(1);
            if (addr_cnt_q == AW'(N - 1)) begin
               if (sym_cnt_q == SW'(REPEAT - 1)) begin
                  sym_cnt_d = '0;
                  last_d    = (len_q == 12'd0);
                  state_d   = (len_q != 12'd0) ? DATA : IDLE;
               end else begin
                  sym_cnt_d = sym_cnt_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (xfer) begin
               pay_cnt_d = pay_cnt_q + 12'd1;
               pay_vld_d = 1'b1;
               pay_re_d  = din_re;
               pay_im_d  = din_im;
               last_d    = (pay_cnt_q == len_q - 12'd1);
               if (pay_cnt_q + 12'd1 == len_q) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         len_q      <= '0;
         addr_cnt_q <= '0;
         sym_cnt_q  <= '0;
         pay_cnt_q  <= '0;
         rd_vld_q   <= 1'b0;
         pay_vld_q  <= 1'b0;
         pay_re_q   <= '0;
         pay_im_q   <= '0;
         last_q     <= 1'b0;
         dout_re_q  <= '0;
         dout_im_q  <= '0;
         dout_vld_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         len_q      <= len_d;
         addr_cnt_q <= addr_cnt_d;
         sym_cnt_q  <= sym_cnt_d;
         pay_cnt_q  <= pay_cnt_d;
         rd_vld_q   <= rd_vld_d;
         pay_vld_q  <= pay_vld_d;
         pay_re_q   <= pay_re_d;
         pay_im_q   <= pay_im_d;
         last_q     <= last_d;
         dout_re_q  <= dout_re_d;
         dout_im_q  <= dout_im_d;
         dout_vld_q <= dout_vld_d;
         done_q     <= done_d;
      end
   end

   assign dout_re  = dout_re_q;
   assign dout_im  = dout_im_q;
   assign dout_vld = dout_vld_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: tb/tb_cest_train_gen.sv
// tb/tb_cest_train_gen.sv - scoreboard bench for cest_train_gen
// Expected samples are queued at stimulus time and checked as dout_vld appears.
module tb_cest_train_gen;
   localparam int N  = 64;
   localparam int R  = 4;
   localparam int AW = 6;
   localparam int RN = R * N;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               tbl_wr_en = 1'b0;
   logic [AW-1:0]      tbl_addr = '0;
   logic signed [11:0] tbl_re = '0, tbl_im = '0;
   logic               start = 1'b0;
   logic [11:0]        len_i = '0;
   logic signed [11:0] din_re = '0, din_im = '0;
   logic               din_vld = 1'b0;
   logic               din_rdy;
   logic signed [11:0] dout_re, dout_im;
   logic               dout_vld, busy, done;

   typedef struct {
      logic signed [11:0] re;
      logic signed [11:0] im;
      logic               last;
   } exp_t;

   exp_t               sb[$];
   logic signed [11:0] tbl_m_re [N];
   logic signed [11:0] tbl_m_im [N];
   int                 n_chk = 0;
   int                 fails = 0;

   int                 pay_len = 0, pay_base = 0, pay_idx = 0, pat_pos = 0, rdy_cnt = 0;
   logic               pat_en = 1'b0;
   logic [15:0]        pat = '0;

   cest_train_gen #(.N(N), .REPEAT(R), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr),
      .tbl_re(tbl_re), .tbl_im(tbl_im), .start(start), .len(len_i),
      .din_re(din_re), .din_im(din_im), .din_vld(din_vld), .din_rdy(din_rdy),
      .dout_re(dout_re), .dout_im(dout_im), .dout_vld(dout_vld),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Payload source: decides din_vld away from the edge and queues what will be accepted.
   always @(negedge clk) begin
      if (!rst_n || !busy) begin
         pay_idx = 0;
         pat_pos = 0;
         rdy_cnt = 0;
         din_vld = 1'b0;
      end else if (din_rdy) begin
         rdy_cnt++;
         din_vld = pat_en ? pat[pat_pos[3:0]] : 1'b1;
         pat_pos++;
         din_re  = 12'(pay_base + pay_idx);
         din_im  = 12'(-(pay_base + pay_idx));
         if (din_vld) begin
            sb.push_back('{re: din_re, im: din_im, last: (pay_idx == pay_len - 1)});
            pay_idx++;
         end
      end else begin
         din_vld = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_vld) begin
            if (sb.size() == 0) begin
               chk("unexpected_vld", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("dout_re", int'(dout_re), int'(e.re));
               chk("dout_im", int'(dout_im), int'(e.im));
               chk("done", int'(done), int'(e.last));
            end
         end else begin
            chk("idle_re", int'(dout_re), 0);
            chk("idle_im", int'(dout_im), 0);
            chk("idle_done", int'(done), 0);
         end
      end
   end

   task automatic push_training(input logic last);
      for (int r = 0; r < R; r++)
         for (int i = 0; i < N; i++)
            sb.push_back('{re: tbl_m_re[i], im: tbl_m_im[i],
                           last: last && (r == R - 1) && (i == N - 1)});
   endtask

   task automatic load_entry(input int a, input int re, input int im);
      @(negedge clk);
      tbl_wr_en = 1'b1;
      tbl_addr  = AW'(a);
      tbl_re    = 12'(re);
      tbl_im    = 12'(im);
      tbl_m_re[a] = 12'(re);
      tbl_m_im[a] = 12'(im);
      @(negedge clk);
      tbl_wr_en = 1'b0;
   endtask

   task automatic start_pulse(input int l);
      @(negedge clk);
      start = 1'b1;
      len_i = 12'(l);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // k counts edges after the start edge E0; done is expected at k = RN+1+len with no stalls.
   task automatic run_frame(input int l, output int done_k, output int first_k,
                            output int nv, output int rdy_n);
      done_k = -1; first_k = -1; nv = 0; rdy_n = 0;
      start_pulse(l);
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (dout_vld) begin
            nv++;
            if (first_k < 0) first_k = k;
         end
         if (done) begin
            done_k = k;
            rdy_n  = rdy_cnt;
            break;
         end
      end
      if (done_k < 0) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("busy_at_done", int'(busy), 1);
         @(negedge clk);
         chk("busy_after_done", int'(busy), 0);
      end
   endtask

   initial begin
      int dk, fk, nv, rn, stray, seen;

      repeat (3) @(negedge clk);
      chk("rst_dout_re", int'(dout_re), 0);
      chk("rst_dout_im", int'(dout_im), 0);
      chk("rst_dout_vld", int'(dout_vld), 0);
      chk("rst_din_rdy", int'(din_rdy), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;

      // Table (i,-i) and a training-only frame.
      for (int i = 0; i < N; i++) load_entry(i, i, -i);
      push_training(1'b1);
      run_frame(0, dk, fk, nv, rn);
      chk("f0_first_k", fk, 2);
      chk("f0_nvalid", nv, RN);
      chk("f0_done_k", dk, RN + 1);

      // Continuous payload of 5.
      pay_len = 5; pay_base = 100; pat_en = 1'b0;
      push_training(1'b0);
      run_frame(5, dk, fk, nv, rn);
      chk("f5_nvalid", nv, RN + 5);
      chk("f5_done_k", dk, RN + 6);
      chk("f5_rdy_cycles", rn, 5);

      // Backpressure: din_vld 1,0,0,1,0,1 while ready.
      pay_len = 3; pay_base = 300; pat_en = 1'b1; pat = 16'b0000_0000_0010_1001;
      push_training(1'b0);
      run_frame(3, dk, fk, nv, rn);
      chk("bp_nvalid", nv, RN + 3);
      chk("bp_done_k", dk, RN + 7);
      chk("bp_rdy_cycles", rn, 6);
      chk("bp_pay_cnt", int'(dut.pay_cnt_q), 3);
      pat_en = 1'b0;

      // start and table write mid-TRAIN must be ignored.
      push_training(1'b1);
      fork
         run_frame(0, dk, fk, nv, rn);
         begin
            repeat (100) @(negedge clk);
            start = 1'b1; tbl_wr_en = 1'b1; tbl_addr = 6'd5; tbl_re = -12'sd2048; tbl_im = 12'sd2047;
            @(negedge clk);
            start = 1'b0; tbl_wr_en = 1'b0;
         end
      join
      chk("ign_nvalid", nv, RN);
      chk("ign_done_k", dk, RN + 1);
      stray = 0;
      repeat (300) begin
         @(negedge clk);
         if (dout_vld || busy) stray++;
      end
      chk("ign_no_second_frame", stray, 0);
      push_training(1'b1);
      run_frame(0, dk, fk, nv, rn);
      chk("ign_replay_done_k", dk, RN + 1);

      // Asynchronous reset at training sample 130, then replay.
      push_training(1'b1);
      start_pulse(0);
      seen = 0;
      for (int k = 0; k < 1000 && seen < 130; k++) begin
         @(negedge clk);
         if (dout_vld) seen++;
      end
      chk("rst_reach_130", seen, 130);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_dout_re", int'(dout_re), 0);
      chk("mid_rst_dout_im", int'(dout_im), 0);
      chk("mid_rst_dout_vld", int'(dout_vld), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_din_rdy", int'(din_rdy), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      push_training(1'b1);
      run_frame(0, dk, fk, nv, rn);
      chk("post_rst_nvalid", nv, RN);
      chk("post_rst_done_k", dk, RN + 1);

      // Extremes: full-scale table entries and a 4095-sample payload.
      for (int i = 0; i < N; i++) begin
         case (i % 4)
            0: load_entry(i, 2047, -2048);
            1: load_entry(i, -2048, 2047);
            2: load_entry(i, (i < 8) ? 2047 : i * 31 - 1000, (i < 8) ? 2047 : 1000 - i * 29);
            default: load_entry(i, -2048, -2048);
         endcase
      end
      pay_len = 4095; pay_base = -2048;
      push_training(1'b0);
      run_frame(4095, dk, fk, nv, rn);
      chk("ext_nvalid", nv, RN + 4095);
      chk("ext_done_k", dk, RN + 4096);
      chk("ext_rdy_cycles", rn, 4095);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
      $finish;
   end
endmodule
